// File: rtl/digitizer_buffer_reader_if.sv
// -----------------------------------------------------------------------------
// digitizer_buffer_reader_if
//
// Bundles every non-clock signal of the digitizer buffer reader into one
// interface.
//
// Signals
//   READ_START   start request, sampled only while the reader is idle
//   READ_COUNT   number of words to drain, sampled with READ_START
//   BUFFER_READ  one-cycle pulse that advances the buffer tail pointer
//   BUFFER_DATA  registered read-port data from the sample buffer
//   OUT_DATA     sample presented downstream
//   OUT_VALID    OUT_DATA is valid
//   OUT_READY    downstream accept
//   BUSY         transfer in progress
//   DONE         one-cycle completion pulse
//
// Modports
//   master  the reader itself (drives BUFFER_READ, OUT_*, BUSY, DONE)
//   slave   the surroundings: start logic, sample buffer and downstream sink
//
// CW must equal $clog2(BUFFER_SIZE)+1 of the connected reader.
// -----------------------------------------------------------------------------
interface digitizer_buffer_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CW         = 10
);
    logic                  READ_START;
    logic [CW-1:0]         READ_COUNT;
    logic                  BUFFER_READ;
    logic [DATA_WIDTH-1:0] BUFFER_DATA;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        input  READ_START,
        input  READ_COUNT,
        input  BUFFER_DATA,
        input  OUT_READY,
        output BUFFER_READ,
        output OUT_DATA,
        output OUT_VALID,
        output BUSY,
        output DONE
    );

    modport slave (
        output READ_START,
        output READ_COUNT,
        output BUFFER_DATA,
        output OUT_READY,
        input  BUFFER_READ,
        input  OUT_DATA,
        input  OUT_VALID,
        input  BUSY,
        input  DONE
    );
endinterface

// File: rtl/digitizer_buffer_reader.sv
// -----------------------------------------------------------------------------
// digitizer_buffer_reader
//
// Read-side controller for the digitizer sample circular buffer. A start
// request latches a word count (clamped to BUFFER_SIZE). The reader then
// presents the word currently on the buffer read port, waits for the
// downstream handshake, and pulses BUFFER_READ to advance the tail. After
// that it waits READ_LATENCY cycles for the buffer to show the next word.
// No advance is issued after the last word, so a count of N produces N-1
// BUFFER_READ pulses and leaves the tail on the last word read.
//
// Ports
//   CLK    system clock, all logic on the rising edge
//   RESET  synchronous active-high reset
//   bus    digitizer_buffer_reader_if.master (start/count, buffer read port,
//          valid/ready output stream, BUSY/DONE status)
//
// Parameters
//   DATA_WIDTH    sample width, must match the buffer
//   BUFFER_SIZE   buffer depth in words, upper bound for the read count
//   READ_LATENCY  cycles from BUFFER_READ until BUFFER_DATA updates (1..15)
// -----------------------------------------------------------------------------
module digitizer_buffer_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int BUFFER_SIZE  = 512,
    parameter int READ_LATENCY = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    digitizer_buffer_reader_if.master bus
);

    localparam int            CW          = $clog2(BUFFER_SIZE) + 1;
    localparam logic [CW-1:0] MAX_COUNT   = CW'(BUFFER_SIZE);
    localparam logic [3:0]    SETTLE_LOAD = 4'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_ADVANCE,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t                state_reg,     state_next;
    logic [CW-1:0]         remaining_reg, remaining_next;
    logic [3:0]            settle_reg,    settle_next;
    logic [DATA_WIDTH-1:0] out_data_reg,  out_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  busy_reg,      busy_next;
    logic                  done_reg,      done_next;

    logic [CW-1:0]         count_clamped;

    // Requests larger than the buffer can never be satisfied, so they are
    // trimmed to one full buffer.
    assign count_clamped = (bus.READ_COUNT > MAX_COUNT) ? MAX_COUNT : bus.READ_COUNT;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            settle_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            settle_reg    <= settle_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        settle_next    = settle_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.READ_START) begin
                    remaining_next = count_clamped;
                    if (count_clamped == '0) begin
                        // Nothing to move: report completion without ever
                        // touching the buffer or the output stream.
                        state_next = S_FINISH;
                    end else begin
                        busy_next  = 1'b1;
                        state_next = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                out_data_next  = bus.BUFFER_DATA;
                out_valid_next = 1'b1;
                state_next     = S_HOLD;
            end

            S_HOLD: begin
                // OUT_DATA is frozen here; only the handshake moves us on.
                if (bus.OUT_READY) begin
                    out_valid_next = 1'b0;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == CW'(1)) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next = S_ADVANCE;
                    end
                end
            end

            S_ADVANCE: begin
                // BUFFER_READ is decoded from this state, so it is exactly
                // one cycle wide and never back-to-back.
                settle_next = SETTLE_LOAD;
                state_next  = S_SETTLE;
            end

            S_SETTLE: begin
                // Spend READ_LATENCY cycles here so the buffer has updated
                // its read port before LOAD samples it.
                settle_next = (settle_reg != 4'd0) ? settle_reg - 4'd1 : 4'd0;
                if (settle_reg <= 4'd1) begin
                    state_next = S_LOAD;
                end
            end

            S_FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.BUFFER_READ = (state_reg == S_ADVANCE);
    assign bus.OUT_DATA    = out_data_reg;
    assign bus.OUT_VALID   = out_valid_reg;
    assign bus.BUSY        = busy_reg;
    assign bus.DONE        = done_reg;

endmodule

// File: doc/digitizer_buffer_reader.md
Name: digitizer_buffer_reader

Overview:
Read-side controller for the digitizer sample circular buffer. On a start request it drains a programmed number of samples from the buffer. It drives the buffer's one-cycle read-advance strobe and waits out the buffer's fixed read latency. Each sample goes out on a valid/ready stream toward the host transfer logic. It sits between the sample buffer and the readout/transmit path.

Parameters:
DATA_WIDTH, 16, sample word width; must match the buffer.
BUFFER_SIZE, 512, buffer depth in words; the upper bound for the read count.
READ_LATENCY, 3, cycles from a BUFFER_READ pulse until BUFFER_DATA shows the next word; legal range 1..15.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RESET  input  1  synchronous, active-high reset.
READ_START  input  1  one-cycle start request; sampled only in IDLE.
READ_COUNT  input  CW  number of words to read, sampled with READ_START; CW = ceil(log2(BUFFER_SIZE))+1.
BUFFER_READ  output  1  one-cycle pulse that advances the buffer tail pointer.
BUFFER_DATA  input  DATA_WIDTH  buffer read-port data, registered inside the buffer.
OUT_DATA  output  DATA_WIDTH  sample presented to the downstream stream.
OUT_VALID  output  1  OUT_DATA is valid.
OUT_READY  input  1  downstream accept; a transfer happens on any cycle with OUT_VALID=1 and OUT_READY=1.
BUSY  output  1  high from the accepted start until DONE.
DONE  output  1  one-cycle pulse when the last word has been transferred, or immediately for a zero count.

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE; BUFFER_READ=0; OUT_VALID=0; OUT_DATA=0; BUSY=0; DONE=0; internal counters=0.
- Precondition: when READ_START is accepted, BUFFER_DATA already holds the word at the current tail.
- IDLE:
  - READ_START=1 latches the count, clamped: if READ_COUNT > BUFFER_SIZE, BUFFER_SIZE is used.
  - Count = 0: go to FINISH next cycle; no BUFFER_READ and no OUT_VALID.
  - Count > 0: go to LOAD; BUSY=1 from the next cycle.
- LOAD (1 cycle): OUT_DATA <= BUFFER_DATA; OUT_VALID <= 1; go to HOLD.
- HOLD:
  - OUT_VALID=1 and OUT_DATA stay stable until OUT_READY=1.
  - On the handshake cycle: OUT_VALID <= 0 and the remaining count is decremented.
  - If the remaining count was 1, go to FINISH; otherwise go to ADVANCE.
- ADVANCE (1 cycle): BUFFER_READ=1 for exactly this cycle; load the settle counter with READ_LATENCY; go to SETTLE.
- SETTLE: decrement the settle counter each cycle; at 0 go to LOAD. LOAD therefore samples BUFFER_DATA exactly READ_LATENCY cycles after the BUFFER_READ cycle.
- FINISH (1 cycle): DONE=1, BUSY <= 0, return to IDLE.
- No BUFFER_READ is issued after the last word. The tail is left pointing at the last word read, so the total number of BUFFER_READ pulses equals count-1.
- Pulse widths: BUFFER_READ is never high on two consecutive cycles. DONE is exactly 1 cycle.
- READ_START while BUSY is ignored; the count is not re-latched.
- OUT_READY may be held high continuously. Steady-state throughput is then one word per READ_LATENCY+3 cycles (LOAD, HOLD, ADVANCE, plus READ_LATENCY settle cycles).
- OUT_READY high outside HOLD has no effect.
- Reset asserted mid-transfer returns the block to IDLE next cycle with all outputs at their reset values. Any buffer tail advance already issued is not undone.
- Widths: the remaining-count register is CW bits, the settle counter is 4 bits, and all compares are unsigned.

Test Plan:
1. Reset then idle → all outputs 0 for 10 cycles; READ_COUNT changes with no start produce no activity.
2. Buffer preloaded 0x0001..0x0004, READ_COUNT=4, OUT_READY tied 1 → OUT_DATA sequence 0x0001, 0x0002, 0x0003, 0x0004; exactly 3 BUFFER_READ pulses, each 3 cycles before the following LOAD; DONE pulses once; BUSY low the cycle after DONE.
3. READ_COUNT=0 → DONE one cycle after the FINISH entry (2 cycles after start); no BUFFER_READ; OUT_VALID never asserted.
4. READ_COUNT=2, OUT_READY held low 20 cycles, then high → OUT_VALID stays high with OUT_DATA stable for the full stall; no BUFFER_READ during the stall; completes normally after release.
5. READ_COUNT=1023 with BUFFER_SIZE=512 → exactly 512 transfers and 511 BUFFER_READ pulses; a second READ_START during the transfer is ignored.
6. RESET asserted during SETTLE of word 3 of 8 → the next cycle has IDLE and all outputs 0; a new READ_START with count 2 then completes with 2 transfers.
